// File: rtl/wb_ahb_bridge_if.sv
// Bus bundle for the Wishbone-slave / AHB-Lite-master bridge.
// The slave modport is the bridge's view; master is the host/AHB side.
interface wb_ahb_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  HRDATA, HREADY, HRESP,
      output wbs_ack_o, wbs_dat_o,
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output HRDATA, HREADY, HRESP,
      input  wbs_ack_o, wbs_dat_o,
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
   );
endinterface

// File: rtl/wb_ahb_bridge.sv
// Wishbone slave to AHB-Lite master bridge: single transfers, wait-state
// timeout, sticky error and timeout flags.
module wb_ahb_bridge #(
   parameter int unsigned TIMEOUT = 255,
   parameter logic [31:0] TO_DATA = 32'hBADC0FFE
) (
   input  logic           HCLK,
   input  logic           HRESETn,
   wb_ahb_bridge_if.slave bus,
   input  logic           err_clr_i,
   output logic           err_o,
   output logic           to_o
);
   localparam int unsigned CNT_W = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [2:0] SZ_BYTE   = 3'b000;
   localparam logic [2:0] SZ_HALF   = 3'b001;
   localparam logic [2:0] SZ_WORD   = 3'b010;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, ACK} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               abort_q, abort_d;
   logic [31:0]        wdat_q, wdat_d;
   logic               ack_q, ack_d;
   logic [31:0]        rdat_q, rdat_d;
   logic [31:0]        haddr_q, haddr_d;
   logic [1:0]         htrans_q, htrans_d;
   logic               hwrite_q, hwrite_d;
   logic [2:0]         hsize_q, hsize_d;
   logic [31:0]        hwdata_q, hwdata_d;
   logic               err_q, err_d, err_set;
   logic               to_q, to_d, to_set;

   logic               sel_ok;
   logic [2:0]         sel_size;
   logic [1:0]         sel_off;
   logic               req, wait_st, timeout_hit, aborting;

   // Byte-select decode into HSIZE and the low address bits
   always_comb begin : sel_decode
      sel_ok   = 1'b1;
      sel_size = SZ_WORD;
      sel_off  = 2'b00;
      case (bus.wbs_sel_i)
         4'b0001: begin sel_size = SZ_BYTE; sel_off = 2'b00; end
         4'b0010: begin sel_size = SZ_BYTE; sel_off = 2'b01; end
         4'b0100: begin sel_size = SZ_BYTE; sel_off = 2'b10; end
         4'b1000: begin sel_size = SZ_BYTE; sel_off = 2'b11; end
         4'b0011: begin sel_size = SZ_HALF; sel_off = 2'b00; end
         4'b1100: begin sel_size = SZ_HALF; sel_off = 2'b10; end
         4'b1111: begin sel_size = SZ_WORD; sel_off = 2'b00; end
         default: sel_ok = 1'b0;
      endcase
   end

   assign req         = (state_q == IDLE) && bus.wbs_cyc_i && bus.wbs_stb_i;
   assign wait_st     = ((state_q == ADDR) || (state_q == DATA)) && !bus.HREADY;
   assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_hit = (TIMEOUT != 0) && wait_st && (cnt_inc == CNT_W'(TIMEOUT));
   // A dropped cyc at any point of the transfer suppresses its ack
   assign aborting    = abort_q || !bus.wbs_cyc_i;

   always_ff @(posedge HCLK or negedge HRESETn) begin : state_reg
      if (!HRESETn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         abort_q  <= 1'b0;
         wdat_q   <= '0;
         ack_q    <= 1'b0;
         rdat_q   <= '0;
         haddr_q  <= '0;
         htrans_q <= TR_IDLE;
         hwrite_q <= 1'b0;
         hsize_q  <= SZ_WORD;
         hwdata_q <= '0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         abort_q  <= abort_d;
         wdat_q   <= wdat_d;
         ack_q    <= ack_d;
         rdat_q   <= rdat_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hwdata_q <= hwdata_d;
         err_q    <= err_d;
         to_q     <= to_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE:  if (req) state_d = sel_ok ? ADDR : ACK;
         ADDR: begin
            if (timeout_hit)      state_d = DRAIN;
            else if (bus.HREADY)  state_d = DATA;
         end
         DATA: begin
            if (timeout_hit)      state_d = DRAIN;
            else if (bus.HREADY)  state_d = aborting ? IDLE : ACK;
         end
         DRAIN: if (bus.HREADY) state_d = IDLE;
         ACK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : next_outputs
      ack_d    = 1'b0;
      rdat_d   = rdat_q;
      haddr_d  = haddr_q;
      htrans_d = htrans_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hwdata_d = hwdata_q;
      wdat_d   = wdat_q;
      cnt_d    = cnt_q;
      abort_d  = abort_q;
      err_set  = 1'b0;
      to_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d   = '0;
               abort_d = 1'b0;
               wdat_d  = bus.wbs_dat_i;
               if (sel_ok) begin
                  htrans_d = TR_NONSEQ;
                  haddr_d  = (bus.wbs_adr_i & 32'hFFFF_FFFC) | {30'd0, sel_off};
                  hwrite_d = bus.wbs_we_i;
                  hsize_d  = sel_size;
               end else begin
                  err_set = 1'b1;
                  rdat_d  = '0;
                  ack_d   = 1'b1;
               end
            end
         end
         ADDR, DATA: begin
            abort_d = aborting;
            if (wait_st) cnt_d = cnt_inc;
            if (timeout_hit) begin
               htrans_d = TR_IDLE;
               to_set   = 1'b1;
               if (!aborting) begin
                  ack_d  = 1'b1;
                  rdat_d = TO_DATA;
               end
            end else if (bus.HREADY) begin
               htrans_d = TR_IDLE;
               if (state_q == ADDR) begin
                  hwdata_d = wdat_q;
               end else begin
                  err_set = bus.HRESP;
                  if (!aborting) begin
                     ack_d = 1'b1;
                     if (bus.HRESP)      rdat_d = 32'hFFFF_FFFF;
                     else if (!hwrite_q) rdat_d = bus.HRDATA;
                  end
               end
            end
         end
         default: ;
      endcase
      // Sticky flags: a set in the same cycle beats the clear
      err_d = err_set || (err_q && !err_clr_i);
      to_d  = to_set  || (to_q  && !err_clr_i);
   end

   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_dat_o = rdat_q;
   assign bus.HADDR     = haddr_q;
   assign bus.HTRANS    = htrans_q;
   assign bus.HWRITE    = hwrite_q;
   assign bus.HSIZE     = hsize_q;
   assign bus.HWDATA    = hwdata_q;
   assign bus.HBURST    = 3'b000;
   assign bus.HPROT     = 4'b0011;
   assign err_o         = err_q;
   assign to_o          = to_q;
endmodule
